// File: rtl/char_sched.sv
// char_sched: buffers character codes in a small FIFO, opens an LCD window for each glyph,
// hands the glyph to the character drawer and advances the text cursor with line/screen wrap.
module char_sched #(
    parameter int          FIFO_DEPTH = 8,
    parameter int          CHAR_W     = 24,
    parameter int          CHAR_H     = 40,
    parameter int          COLS       = 20,
    parameter int          ROWS       = 20,
    parameter logic [31:0] NL_CODE    = 32'h0000_000A
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        code_valid,
    input  logic [31:0] code,
    output logic        code_ready,
    input  logic        cur_home,
    output logic        win_req,
    output logic [9:0]  win_x0,
    output logic [9:0]  win_x1,
    output logic [9:0]  win_y0,
    output logic [9:0]  win_y1,
    input  logic        win_ack,
    output logic        char_work,
    output logic [31:0] cpu_code,
    input  logic        write_str_end,
    output logic [4:0]  cur_col,
    output logic [4:0]  cur_row,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SET_WIN   = 3'd1;
    localparam logic [2:0] WAIT_WIN  = 3'd2;
    localparam logic [2:0] DRAW      = 3'd3;
    localparam logic [2:0] WAIT_DRAW = 3'd4;
    localparam logic [2:0] ADVANCE   = 3'd5;

    localparam logic [9:0]  CW       = 10'(CHAR_W);
    localparam logic [9:0]  CH       = 10'(CHAR_H);
    localparam logic [4:0]  LAST_COL = 5'(COLS - 1);
    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);

    logic [2:0]  state;
    logic [31:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [31:0] head;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        home_pend;
    logic        is_nl;

    function automatic logic [4:0] next_row(input logic [4:0] row);
        return (row == LAST_ROW) ? 5'd0 : row + 5'd1;
    endfunction

    function automatic logic [9:0] cell_origin(input logic [4:0] idx, input logic [9:0] size);
        return {5'd0, idx} * size;
    endfunction

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign code_ready = !full;
    assign push       = code_valid && !full;
    assign pop        = (state == IDLE) && !home_pend && !cur_home && !empty;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign win_req    = (state == WAIT_WIN);
    assign char_work  = (state == DRAW);
    assign busy       = (state != IDLE) || !empty;

    always_ff @(posedge pclk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= code;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            home_pend <= 1'b0;
            is_nl     <= 1'b0;
            cpu_code  <= '0;
            win_x0    <= '0;
            win_x1    <= '0;
            win_y0    <= '0;
            win_y1    <= '0;
            cur_col   <= '0;
            cur_row   <= '0;
        end else begin
            if (cur_home && state != IDLE) begin
                home_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (home_pend || cur_home) begin
                        cur_col   <= '0;
                        cur_row   <= '0;
                        home_pend <= 1'b0;
                    end else if (!empty) begin
                        cpu_code <= head;
                        is_nl    <= (head == NL_CODE);
                        state    <= (head == NL_CODE) ? ADVANCE : SET_WIN;
                    end
                end
                SET_WIN: begin
                    win_x0 <= cell_origin(cur_col, CW);
                    win_x1 <= cell_origin(cur_col, CW) + CW - 10'd1;
                    win_y0 <= cell_origin(cur_row, CH);
                    win_y1 <= cell_origin(cur_row, CH) + CH - 10'd1;
                    state  <= WAIT_WIN;
                end
                WAIT_WIN: begin
                    if (win_ack) begin
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    state <= WAIT_DRAW;
                end
                WAIT_DRAW: begin
                    if (write_str_end) begin
                        state <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    // A home request raised while busy wins over the normal cursor step.
                    if (home_pend) begin
                        cur_col <= '0;
                        cur_row <= '0;
                    end else if (is_nl || cur_col == LAST_COL) begin
                        cur_col <= '0;
                        cur_row <= next_row(cur_row);
                    end else begin
                        cur_col <= cur_col + 5'd1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_char_sched.sv
// Directed bench for char_sched: plays the LCD controller and character drawer by hand
// and compares outputs against hand-computed window, cursor and handshake values.
module tb_char_sched;
    localparam logic [31:0] NL = 32'h0000_000A;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        code_valid = 1'b0;
    logic [31:0] code = '0;
    logic        code_ready;
    logic        cur_home = 1'b0;
    logic        win_req;
    logic [9:0]  win_x0;
    logic [9:0]  win_x1;
    logic [9:0]  win_y0;
    logic [9:0]  win_y1;
    logic        win_ack = 1'b0;
    logic        char_work;
    logic [31:0] cpu_code;
    logic        write_str_end = 1'b0;
    logic [4:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;

    int   vectors = 0;
    int   miscompares = 0;
    logic saw_req;
    logic saw_work;

    always #5 pclk = ~pclk;

    char_sched #(
        .FIFO_DEPTH(8),
        .CHAR_W(24),
        .CHAR_H(40),
        .COLS(20),
        .ROWS(20),
        .NL_CODE(NL)
    ) dut (
        .pclk(pclk),
        .rst(rst),
        .code_valid(code_valid),
        .code(code),
        .code_ready(code_ready),
        .cur_home(cur_home),
        .win_req(win_req),
        .win_x0(win_x0),
        .win_x1(win_x1),
        .win_y0(win_y0),
        .win_y1(win_y1),
        .win_ack(win_ack),
        .char_work(char_work),
        .cpu_code(cpu_code),
        .write_str_end(write_str_end),
        .cur_col(cur_col),
        .cur_row(cur_row),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cursor(input string tag, input int col, input int row);
        check({tag, "_col"}, 32'(cur_col), 32'(col));
        check({tag, "_row"}, 32'(cur_row), 32'(row));
    endtask

    task automatic push_one(input logic [31:0] c);
        code       = c;
        code_valid = 1'b1;
        @(negedge pclk);
        code_valid = 1'b0;
    endtask

    task automatic pulse_home();
        cur_home = 1'b1;
        @(negedge pclk);
        cur_home = 1'b0;
    endtask

    task automatic serve_win(input int col, input int row);
        int         n;
        logic [9:0] x0;
        logic [9:0] x1;
        logic [9:0] y0;
        logic [9:0] y1;
        logic       stable;
        n = 0;
        while (win_req !== 1'b1 && n < 20) begin
            @(negedge pclk);
            n++;
        end
        check("win_req_rise", 32'(win_req), 32'd1);
        check("win_x0", 32'(win_x0), 32'(col * 24));
        check("win_x1", 32'(win_x1), 32'(col * 24 + 23));
        check("win_y0", 32'(win_y0), 32'(row * 40));
        check("win_y1", 32'(win_y1), 32'(row * 40 + 39));
        x0 = win_x0;
        x1 = win_x1;
        y0 = win_y0;
        y1 = win_y1;
        stable = 1'b1;
        repeat (3) begin
            @(negedge pclk);
            if (win_req !== 1'b1 || win_x0 !== x0 || win_x1 !== x1 || win_y0 !== y0 || win_y1 !== y1)
                stable = 1'b0;
        end
        check("win_hold", 32'(stable), 32'd1);
        win_ack = 1'b1;
        @(negedge pclk);
        win_ack = 1'b0;
    endtask

    task automatic serve_draw(input logic [31:0] c);
        int n;
        n = 0;
        while (char_work !== 1'b1 && n < 10) begin
            @(negedge pclk);
            n++;
        end
        check("char_work", 32'(char_work), 32'd1);
        check("win_req_drop", 32'(win_req), 32'd0);
        check("cpu_code", cpu_code, c);
        @(negedge pclk);
        check("char_work_single", 32'(char_work), 32'd0);
    endtask

    task automatic finish_draw();
        repeat (9) @(negedge pclk);
        write_str_end = 1'b1;
        @(negedge pclk);
        write_str_end = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
    endtask

    task automatic glyph(input logic [31:0] c, input int col, input int row);
        push_one(c);
        serve_win(col, row);
        serve_draw(c);
        finish_draw();
    endtask

    task automatic newline_quiet(input int cycles);
        push_one(NL);
        saw_req  = 1'b0;
        saw_work = 1'b0;
        repeat (cycles) begin
            @(negedge pclk);
            if (win_req === 1'b1) saw_req = 1'b1;
            if (char_work === 1'b1) saw_work = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        @(negedge pclk);
        check("rst_code_ready", 32'(code_ready), 32'd1);
        check("rst_win_req", 32'(win_req), 32'd0);
        check("rst_char_work", 32'(char_work), 32'd0);
        check("rst_cpu_code", cpu_code, 32'd0);
        check("rst_win", {win_x0[7:0], win_x1[7:0], win_y0[7:0], win_y1[7:0]}, 32'd0);
        check_cursor("rst", 0, 0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single glyph at the origin
        glyph(32'h41, 0, 0);
        check_cursor("single", 1, 0);
        check("single_busy", 32'(busy), 32'd0);

        // 21 glyphs from the origin: line wrap after column 19
        rst = 1'b1;
        @(negedge pclk);
        rst = 1'b0;
        @(negedge pclk);
        check_cursor("rst2", 0, 0);
        for (int i = 0; i < 21; i++) begin
            glyph(32'h100 + 32'(i), i % 20, i / 20);
        end
        check_cursor("wrap", 1, 1);

        // Home in IDLE, 19 newlines, 5 glyphs on the last row, then a wrapping newline
        pulse_home();
        @(negedge pclk);
        check_cursor("home_idle", 0, 0);
        for (int i = 0; i < 19; i++) begin
            newline_quiet(3);
        end
        check_cursor("nl19", 0, 19);
        for (int k = 0; k < 5; k++) begin
            glyph(32'h30 + 32'(k), k, 19);
        end
        check_cursor("row19", 5, 19);
        newline_quiet(4);
        check("nl_no_win_req", 32'(saw_req), 32'd0);
        check("nl_no_char_work", 32'(saw_work), 32'd0);
        check_cursor("nl_wrap", 0, 0);

        // Fill the FIFO while the drawer is stalled
        push_one(32'h50);
        serve_win(0, 0);
        serve_draw(32'h50);
        for (int k = 0; k < 8; k++) begin
            code       = 32'h60 + 32'(k);
            code_valid = 1'b1;
            @(negedge pclk);
        end
        check("full_ready", 32'(code_ready), 32'd0);
        code = 32'h99;
        @(negedge pclk);
        code_valid = 1'b0;
        check("full_ready_9th", 32'(code_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        write_str_end = 1'b1;
        @(negedge pclk);
        write_str_end = 1'b0;
        n = 0;
        while (code_ready !== 1'b1 && n < 5) begin
            @(negedge pclk);
            n++;
        end
        check("ready_after_pop", 32'(code_ready), 32'd1);
        for (int k = 0; k < 8; k++) begin
            serve_win(k + 1, 0);
            serve_draw(32'h60 + 32'(k));
            finish_draw();
        end
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_last_code", cpu_code, 32'h67);
        check_cursor("drain", 9, 0);

        // Home requested during WAIT_DRAW overrides the advance
        pulse_home();
        @(negedge pclk);
        newline_quiet(3);
        newline_quiet(3);
        for (int k = 0; k < 3; k++) begin
            glyph(32'h20 + 32'(k), k, 2);
        end
        check_cursor("pre_home", 3, 2);
        push_one(32'h77);
        serve_win(3, 2);
        serve_draw(32'h77);
        pulse_home();
        finish_draw();
        check_cursor("home_pend", 0, 0);
        glyph(32'h78, 0, 0);
        check_cursor("after_home", 1, 0);

        // Reset while waiting for the window acknowledge
        push_one(32'hA1);
        push_one(32'hA2);
        n = 0;
        while (win_req !== 1'b1 && n < 20) begin
            @(negedge pclk);
            n++;
        end
        check("pre_rst_win_req", 32'(win_req), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_win_req", 32'(win_req), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        check_cursor("rst_async", 0, 0);
        @(negedge pclk);
        rst = 1'b0;
        check("post_rst_ready", 32'(code_ready), 32'd1);
        saw_req = 1'b0;
        repeat (5) begin
            @(negedge pclk);
            if (win_req === 1'b1) saw_req = 1'b1;
        end
        check("post_rst_idle", 32'(saw_req), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_cpu_code", cpu_code, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/char_sched.md
# char_sched

Sequencing controller for the character drawer. Accepts a stream of 32-bit character codes from the CPU-side bus into a small FIFO, and places each glyph on screen. For every glyph it computes the LCD window from a text cursor, requests that window from the LCD controller, then pulses `char_work` to the character drawer and waits for `write_str_end`. It then advances the cursor with line and screen wrap.

## Interface

Parameters:
- `FIFO_DEPTH`, 8: code FIFO entries (power of two).
- `CHAR_W`, 24: glyph width in pixels.
- `CHAR_H`, 40: glyph height in pixels.
- `COLS`, 20: text columns (COLS*CHAR_W ≤ 1024).
- `ROWS`, 20: text rows (ROWS*CHAR_H ≤ 1024).
- `NL_CODE`, 32'h0000_000A: newline code; consumed, never drawn.

Ports (one clock; reset is asynchronous and active-high):
- `pclk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `code_valid` in 1: CPU offers a code.
- `code` in 32: character code.
- `code_ready` out 1: FIFO can accept; equals !full.
- `cur_home` in 1: one-cycle request to move the cursor to (0,0).
- `win_req` out 1: window-set request to the LCD controller.
- `win_x0` out 10, `win_x1` out 10, `win_y0` out 10, `win_y1` out 10: window corners, inclusive.
- `win_ack` in 1: LCD controller has applied the window.
- `char_work` out 1: one-cycle start pulse to the character drawer.
- `cpu_code` out 32: code for the current glyph.
- `write_str_end` in 1: drawer finished the current glyph.
- `cur_col` out 5: cursor column.
- `cur_row` out 5: cursor row.
- `busy` out 1: state != IDLE, or FIFO not empty.

## Operation

- FIFO
  - Push when `code_valid && code_ready`.
  - Pop only in IDLE when not empty.
  - No bypass: a push to an empty FIFO is poppable the following cycle.
  - A push while full is dropped; the CPU must hold `code_valid` until it sees `code_ready`.
- States: IDLE, SET_WIN, WAIT_WIN, DRAW, WAIT_DRAW, ADVANCE.
- IDLE
  - If `home_pend`: cursor ← (0,0), clear `home_pend`, no pop this cycle.
  - Else if FIFO is not empty: pop into `cpu_code`. Go to ADVANCE if the code == NL_CODE, otherwise to SET_WIN.
- SET_WIN: register the window.
  - `win_x0 = cur_col*CHAR_W`, `win_x1 = win_x0 + CHAR_W - 1`.
  - `win_y0 = cur_row*CHAR_H`, `win_y1 = win_y0 + CHAR_H - 1`.
  - Compute at 10-bit width. Go to WAIT_WIN.
- WAIT_WIN: `win_req` = 1 and window outputs held stable. When `win_ack` is sampled 1, drop `win_req` next cycle and go to DRAW.
- DRAW: `char_work` = 1 for exactly this cycle. Go to WAIT_DRAW.
- WAIT_DRAW: wait for `write_str_end` = 1, then go to ADVANCE. A `write_str_end` arriving in any other state is ignored.
- ADVANCE, newline:
  - `cur_col` ← 0.
  - `cur_row` ← (cur_row == ROWS-1) ? 0 : cur_row+1.
- ADVANCE, glyph:
  - If cur_col == COLS-1: `cur_col` ← 0, row advances as for newline.
  - Else `cur_col` ← cur_col+1.
  - Go to IDLE.
- `cur_home`
  - Sampled every cycle. In IDLE it applies directly (takes precedence over pop).
  - Otherwise it sets `home_pend`, applied at the next IDLE. A pending home overrides the ADVANCE result.
- `cpu_code` holds the last popped code until the next pop.
- Reset values:
  - FSM = IDLE; FIFO empty; `code_ready` = 1; `home_pend` = 0.
  - `win_req` = 0, `char_work` = 0, `cpu_code` = 0, all window outputs = 0.
  - `cur_col` = 0, `cur_row` = 0, `busy` = 0.
- Reset mid-operation: all of the above apply immediately. A glyph partially drawn in the drawer is abandoned; the drawer has its own reset.

## Timing

- Push at cycle t: earliest pop at t+1 (IDLE). SET_WIN at t+2. `win_req` high from t+3.
- `win_ack` sampled at cycle a: `char_work` at a+1; WAIT_DRAW from a+2.
- `write_str_end` sampled at cycle e: ADVANCE at e+1, cursor updated and IDLE at e+2. Next pop at e+2.
- Newline: pop, ADVANCE, IDLE; 2 cycles per code after the pop.
- `win_req` and window corners must not change while `win_req` = 1.
- `char_work` is never high for 2 consecutive cycles.
- At most one glyph is outstanding at the drawer.

## Test plan

- Reset, then push 0x41 at (0,0); ack `win_req` after 3 cycles, assert `write_str_end` 10 cycles after `char_work`:
  - window (0,0)-(23,39); single `char_work` pulse with `cpu_code` = 0x41.
  - cursor (1,0); `busy` returns to 0.
- 21 glyphs back-to-back:
  - 20th glyph window (456,0)-(479,39).
  - 21st glyph window (0,40)-(23,79); cursor ends at (1,1).
- Cursor at (5,19), push NL_CODE:
  - no `win_req` and no `char_work`; cursor becomes (0,0).
- Fill the FIFO with 8 codes while the drawer is stalled:
  - `code_ready` = 0; a 9th `code_valid` is dropped.
  - After one `write_str_end`, `code_ready` returns to 1.
- `cur_home` pulsed during WAIT_DRAW with cursor at (3,2):
  - after `write_str_end`, cursor is (0,0), not (4,2); next glyph window is (0,0)-(23,39).
- Assert `rst` while in WAIT_WIN:
  - `win_req` drops in the same cycle; FIFO empty; cursor (0,0); `code_ready` = 1 after release.
